// File: rtl/multi_chnnl_trig_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_chnnl_trig_if
// Brief    : Bus bundle between capture control and the multi-channel trigger.
//            trig_cnt exists only when TRIG_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_chnnl_trig_if #(
  parameter int NUM_CH    = 5,
  parameter int HOLDOFF_W = 16
);
  logic                   armed;
  logic [NUM_CH-1:0]      CH_Hff5;
  logic [NUM_CH-1:0]      CH_Lff5;
  logic [5*NUM_CH-1:0]    CH_TrigCfg;
  logic                   trig_mode;
  logic [HOLDOFF_W-1:0]   holdoff;
  logic                   trig_clr;
  logic                   triggered;
  logic                   trig_pulse;
  logic [NUM_CH-1:0]      ch_hit;
`ifdef TRIG_CNT_EN
  logic [15:0]            trig_cnt;

  modport master (
    output armed, CH_Hff5, CH_Lff5, CH_TrigCfg, trig_mode, holdoff, trig_clr,
    input  triggered, trig_pulse, ch_hit, trig_cnt
  );
  modport slave (
    input  armed, CH_Hff5, CH_Lff5, CH_TrigCfg, trig_mode, holdoff, trig_clr,
    output triggered, trig_pulse, ch_hit, trig_cnt
  );
`else
  modport master (
    output armed, CH_Hff5, CH_Lff5, CH_TrigCfg, trig_mode, holdoff, trig_clr,
    input  triggered, trig_pulse, ch_hit
  );
  modport slave (
    input  armed, CH_Hff5, CH_Lff5, CH_TrigCfg, trig_mode, holdoff, trig_clr,
    output triggered, trig_pulse, ch_hit
  );
`endif
endinterface
`default_nettype wire

// File: rtl/multi_chnnl_trig.sv
`default_nettype none
// ============================================================================
// Module   : multi_chnnl_trig
// Brief    : NUM_CH-channel edge/level trigger with OR/AND combine, post-arm
//            holdoff and sticky capture flag. Define TRIG_CNT_EN for trig_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module multi_chnnl_trig #(
  parameter int NUM_CH    = 5,
  parameter int HOLDOFF_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  multi_chnnl_trig_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLDOFF = 2'd1,
    S_WAIT    = 2'd2,
    S_TRIG    = 2'd3
  } state_t;

  localparam logic [HOLDOFF_W-1:0] c_HOLD_ONE = HOLDOFF_W'(1);

  state_t                state_q, state_d;
  logic [HOLDOFF_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [NUM_CH-1:0]     h_prev_q, l_prev_q;
  logic [NUM_CH-1:0]     pos_s_q, pos_s_d, neg_s_q, neg_s_d;
  logic                  triggered_q, triggered_d;
  logic                  pulse_q, pulse_d;
  logic [NUM_CH-1:0]     ch_hit_q, ch_hit_d;

  logic [NUM_CH-1:0]     w_pos, w_neg, w_ct, w_active;
  logic                  w_hit;
  state_t                w_run_state;

  // h_prev/l_prev double as the level flops: both sample the inputs every cycle.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [4:0] w_cfg;
    assign w_cfg       = bus.CH_TrigCfg[5*i +: 5];
    assign w_pos[i]    = bus.CH_Hff5[i] & ~h_prev_q[i];
    assign w_neg[i]    = ~bus.CH_Lff5[i] & l_prev_q[i];
    assign w_active[i] = |w_cfg[4:1];
    assign w_ct[i]     = (pos_s_q[i] & w_cfg[4]) | (neg_s_q[i] & w_cfg[3]) |
                         (h_prev_q[i] & w_cfg[2]) | (~l_prev_q[i] & w_cfg[1]) |
                         w_cfg[0];
  end

  assign w_hit       = bus.trig_mode ? (&w_ct) : (|(w_ct & w_active));
  assign w_run_state = (bus.holdoff != '0) ? S_HOLDOFF : S_WAIT;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pos_s_d     = pos_s_q;
    neg_s_d     = neg_s_q;
    triggered_d = triggered_q;
    pulse_d     = 1'b0;
    ch_hit_d    = ch_hit_q;
    case (state_q)
      S_IDLE: begin
        pos_s_d = '0;
        neg_s_d = '0;
        if (bus.armed) begin
          hold_cnt_d = bus.holdoff;
          state_d    = w_run_state;
        end
      end
      S_HOLDOFF: begin
        pos_s_d    = '0;
        neg_s_d    = '0;
        hold_cnt_d = hold_cnt_q - c_HOLD_ONE;
        if (hold_cnt_q == c_HOLD_ONE) state_d = S_WAIT;
      end
      S_WAIT: begin
        pos_s_d = pos_s_q | w_pos;
        neg_s_d = neg_s_q | w_neg;
        if (w_hit) begin
          state_d     = S_TRIG;
          triggered_d = 1'b1;
          pulse_d     = 1'b1;
          ch_hit_d    = w_ct & w_active;
        end
      end
      S_TRIG: begin
        if (bus.trig_clr) begin
          pos_s_d     = '0;
          neg_s_d     = '0;
          triggered_d = 1'b0;
          ch_hit_d    = '0;
          hold_cnt_d  = bus.holdoff;
          state_d     = w_run_state;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disarm overrides any concurrent re-arm or hit.
    if (!bus.armed) begin
      state_d     = S_IDLE;
      pos_s_d     = '0;
      neg_s_d     = '0;
      triggered_d = 1'b0;
      pulse_d     = 1'b0;
      ch_hit_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      h_prev_q    <= '0;
      l_prev_q    <= '0;
      pos_s_q     <= '0;
      neg_s_q     <= '0;
      triggered_q <= 1'b0;
      pulse_q     <= 1'b0;
      ch_hit_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      h_prev_q    <= bus.CH_Hff5;
      l_prev_q    <= bus.CH_Lff5;
      pos_s_q     <= pos_s_d;
      neg_s_q     <= neg_s_d;
      triggered_q <= triggered_d;
      pulse_q     <= pulse_d;
      ch_hit_q    <= ch_hit_d;
    end
  end

  assign bus.triggered  = triggered_q;
  assign bus.trig_pulse = pulse_q;
  assign bus.ch_hit     = ch_hit_q;

`ifdef TRIG_CNT_EN
  logic [15:0] trig_cnt_q;

  // Counts on the edge that raises trig_pulse so the count is visible with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_cnt_q <= '0;
    end else if (pulse_d && (trig_cnt_q != 16'hFFFF)) begin
      trig_cnt_q <= trig_cnt_q + 16'd1;
    end
  end

  assign bus.trig_cnt = trig_cnt_q;
`endif

endmodule
`default_nettype wire
